carus_clk_gate_ctrl: RTL
========================

CARUS_CLK_GATE_CTRL -- requirements
Module: carus_clk_gate_ctrl

Interface
REQ-001 SHALL have parameter IDLE_CNT_W, default 8, width of the idle threshold and idle counter.
REQ-002 SHALL have parameter WAKE_LAT, default 2, number of enabled-clock cycles between wake and acknowledge (legal range 1..15).
REQ-003 SHALL have parameter STAT_W, default 16, width of the gated-cycle statistics counter.
REQ-004 clk_i  input  1  free-running clock, ungated; the whole block runs on it; one clock only.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 busy_i  input  1  the gated unit has work in flight.
REQ-007 wake_req_i  input  1  wake request level; held high until wake_ack_o is seen.
REQ-008 force_en_i  input  1  software override; 1 keeps the clock enabled.
REQ-009 idle_thr_i  input  IDLE_CNT_W  consecutive idle cycles required before gating; 0 disables gating.
REQ-010 stat_clr_i  input  1  synchronous clear of stat_cnt_o.
REQ-011 cg_en_o  output  1  registered enable driving en_i of carus_clk_gate_wrapper.
REQ-012 gated_o  output  1  1 while in GATED.
REQ-013 wake_ack_o  output  1  one-cycle acknowledge pulse.
REQ-014 stat_cnt_o  output  STAT_W  saturating count of cycles spent in GATED.

Function
REQ-015 The block SHALL implement a four-state FSM: RUN, IDLE_WAIT, GATED, WAKE.
REQ-016 Idle condition: busy_i=0, wake_req_i=0, force_en_i=0, idle_thr_i!=0.
REQ-017 RUN: cg_en_o=1; idle condition -> IDLE_WAIT with idle counter loaded to 1; otherwise stay.
REQ-018 IDLE_WAIT: cg_en_o=1; idle condition false -> RUN, counter cleared; counter==idle_thr_i -> GATED; otherwise counter increments.
REQ-019 idle_thr_i=1: the first idle cycle in RUN enters IDLE_WAIT, and the following cycle enters GATED if still idle.
REQ-020 Changes to idle_thr_i during IDLE_WAIT SHALL take effect on the next comparison; if the counter already exceeds the new value, the next cycle -> GATED.
REQ-021 GATED: cg_en_o=0, gated_o=1; any of wake_req_i, busy_i, force_en_i -> WAKE in the next cycle.
REQ-022 In GATED, stat_cnt_o SHALL increment once per cycle, saturate at all-ones, and not wrap.
REQ-023 stat_clr_i SHALL clear stat_cnt_o to 0 and take priority over an increment in the same cycle.
REQ-024 WAKE: cg_en_o=1, gated_o=0; a wake counter counts WAKE_LAT cycles, then -> RUN.
REQ-025 On the WAKE->RUN transition, wake_ack_o=1 for one cycle if wake_req_i=1.
REQ-026 In RUN or IDLE_WAIT, wake_req_i=1 with wake_ack_o=0 in the previous cycle SHALL produce wake_ack_o=1 in the next cycle.
REQ-027 wake_ack_o SHALL never be high for two consecutive cycles.
REQ-028 Latency: cg_en_o falls 1 cycle after the cycle in which IDLE_WAIT reaches the threshold, and rises 1 cycle after the wake event is sampled in GATED.
REQ-029 wake_req_i that drops before ack SHALL be tolerated: WAKE completes and no ack is issued.
REQ-030 Simultaneous threshold match and a wake event in IDLE_WAIT: wake wins -> RUN, with no gating.

Reset
REQ-031 rst_i SHALL put the FSM in RUN and set cg_en_o=1, gated_o=0, wake_ack_o=0, stat_cnt_o=0, and both counters to 0.
REQ-032 rst_i asserted in any state, including GATED, SHALL re-enable the clock on the next cycle.

Structure
REQ-033 The FSM state enum and WAKE_LAT limits SHALL live in a shared carus_pkg.
REQ-034 The saturating statistics counter SHALL be one sub-module, carus_sat_counter; everything else is flat.
REQ-035 cg_en_o SHALL come directly from a flop; there SHALL be no combinational path from inputs to cg_en_o.

Verification
REQ-036 Gating: idle_thr_i=4, busy_i 1->0 at cycle 10 -> IDLE_WAIT at cycle 11, cg_en_o=0 from cycle 15, gated_o=1.
REQ-037 Wake: in GATED, wake_req_i=1 at cycle T, WAKE_LAT=2 -> cg_en_o=1 at T+1, wake_ack_o pulse at T+3, RUN at T+3.
REQ-038 Abort: idle_thr_i=4, busy_i pulses high at the 3rd idle cycle -> back to RUN, cg_en_o never 0.
REQ-039 Saturation: STAT_W=4, 20 cycles GATED -> stat_cnt_o=15; stat_clr_i together with a GATED cycle -> stat_cnt_o=0.
REQ-040 Disable and override: idle_thr_i=0 or force_en_i=1, idle for 100 cycles -> cg_en_o stays 1, state RUN.
REQ-041 Reset in GATED: rst_i for 1 cycle -> next cycle cg_en_o=1, stat_cnt_o=0, state RUN.

Source files
------------

// File: rtl/carus_pkg.sv
// Shared types and limits for the carus clock-gating control logic.
package carus_pkg;

  typedef enum logic [1:0] {
    StRun,
    StIdleWait,
    StGated,
    StWake
  } cg_state_e;

  localparam int unsigned WakeLatMin = 1;
  localparam int unsigned WakeLatMax = 15;
  localparam int unsigned WakeCntW   = $clog2(WakeLatMax + 1);

  // Out-of-range wake latencies are pulled back into the legal window.
  function automatic int unsigned wake_lat_clamp(input int unsigned lat);
    if (lat < WakeLatMin) return WakeLatMin;
    if (lat > WakeLatMax) return WakeLatMax;
    return lat;
  endfunction

endpackage

// File: rtl/carus_sat_counter.sv
// Saturating up-counter with a synchronous clear that beats increment.
module carus_sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + Width'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/carus_clk_gate_ctrl.sv
// Idle-driven clock-gate enable controller: RUN -> IDLE_WAIT -> GATED -> WAKE -> RUN.
// All outputs are flopped; cg_en_o has no combinational path from inputs.
module carus_clk_gate_ctrl
  import carus_pkg::*;
#(
  parameter int unsigned IDLE_CNT_W = 8,
  parameter int unsigned WAKE_LAT   = 2,
  parameter int unsigned STAT_W     = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  busy_i,
  input  logic                  wake_req_i,
  input  logic                  force_en_i,
  input  logic [IDLE_CNT_W-1:0] idle_thr_i,
  input  logic                  stat_clr_i,
  output logic                  cg_en_o,
  output logic                  gated_o,
  output logic                  wake_ack_o,
  output logic [STAT_W-1:0]     stat_cnt_o
);

  localparam logic [WakeCntW-1:0] WakeLatV = WakeCntW'(wake_lat_clamp(WAKE_LAT));

  cg_state_e             state_q;
  logic [IDLE_CNT_W-1:0] idle_cnt_q;
  logic [WakeCntW-1:0]   wake_cnt_q;
  logic                  cg_en_q;
  logic                  gated_q;
  logic                  ack_q;

  logic idle_cond;
  logic wake_evt;

  assign idle_cond = !busy_i && !wake_req_i && !force_en_i && (idle_thr_i != '0);
  assign wake_evt  = wake_req_i || busy_i || force_en_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StRun;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
      cg_en_q    <= 1'b1;
      gated_q    <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      unique case (state_q)
        StRun: begin
          if (idle_cond) begin
            state_q    <= StIdleWait;
            idle_cnt_q <= IDLE_CNT_W'(1);
          end else begin
            ack_q <= wake_req_i && !ack_q;
          end
        end
        StIdleWait: begin
          // Leaving idle wins over a threshold match in the same cycle.
          if (!idle_cond) begin
            state_q    <= StRun;
            idle_cnt_q <= '0;
            ack_q      <= wake_req_i && !ack_q;
          end else if (idle_cnt_q >= idle_thr_i) begin
            state_q    <= StGated;
            idle_cnt_q <= '0;
            cg_en_q    <= 1'b0;
            gated_q    <= 1'b1;
          end else begin
            idle_cnt_q <= idle_cnt_q + IDLE_CNT_W'(1);
          end
        end
        StGated: begin
          if (wake_evt) begin
            state_q    <= StWake;
            wake_cnt_q <= WakeCntW'(1);
            cg_en_q    <= 1'b1;
            gated_q    <= 1'b0;
          end
        end
        StWake: begin
          if (wake_cnt_q >= WakeLatV) begin
            state_q    <= StRun;
            wake_cnt_q <= '0;
            ack_q      <= wake_req_i;
          end else begin
            wake_cnt_q <= wake_cnt_q + WakeCntW'(1);
          end
        end
        default: begin
          state_q    <= StRun;
          idle_cnt_q <= '0;
          wake_cnt_q <= '0;
          cg_en_q    <= 1'b1;
          gated_q    <= 1'b0;
        end
      endcase
    end
  end

  carus_sat_counter #(
    .Width(STAT_W)
  ) u_stat_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (stat_clr_i),
    .inc_i (state_q == StGated),
    .cnt_o (stat_cnt_o)
  );

  assign cg_en_o    = cg_en_q;
  assign gated_o    = gated_q;
  assign wake_ack_o = ack_q;

endmodule
